// File: rtl/mm_arb.sv
// mm_arb: shares the mm write port between the ALU and VLD requesters and the
// registered read port between two operand fetchers, round-robin per port.
module mm_arb #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 63
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  alu_wr_req,
  input  logic [ADDR_WIDTH:0]   alu_wr_addr,
  input  logic [DATA_WIDTH:0]   alu_wr_data,
  output logic                  alu_wr_ack,
  input  logic                  vld_wr_req,
  input  logic [ADDR_WIDTH:0]   vld_wr_addr,
  input  logic [DATA_WIDTH:0]   vld_wr_data,
  output logic                  vld_wr_ack,

  input  logic                  rd0_req,
  input  logic [ADDR_WIDTH:0]   rd0_addr,
  output logic                  rd0_ack,
  output logic                  rd0_vld,
  input  logic                  rd1_req,
  input  logic [ADDR_WIDTH:0]   rd1_addr,
  output logic                  rd1_ack,
  output logic                  rd1_vld,
  output logic [DATA_WIDTH:0]   rd_data,

  output logic [ADDR_WIDTH:0]   mm_Aa,
  output logic [ADDR_WIDTH:0]   mm_Ab,
  output logic [DATA_WIDTH:0]   mm_Db,
  output logic                  mm_req_wr,
  input  logic [DATA_WIDTH:0]   mm_Da
);

  // Handshake: a requester raises req with stable addr/data and holds it until
  // acked; ack is combinational and the transfer happens on the edge where
  // req && ack. Reads answer with a one-cycle rdN_vld pulse two edges later.

  // 1 means ALU (resp. rd0) won the latest transfer, so the other side wins a tie.
  logic wr_last;
  logic rd_last;

  logic s1_valid;
  logic s1_id;
  logic s2_valid;
  logic s2_id;

  logic rd0_cand;
  logic rd1_cand;
  logic wr_xfer;
  logic rd_xfer;

  always_comb begin
    alu_wr_ack = rst && alu_wr_req && (!vld_wr_req || !wr_last);
    vld_wr_ack = rst && vld_wr_req && (!alu_wr_req || wr_last);

    // A read of the address whose write is still on the port waits a cycle.
    rd0_cand   = rd0_req && !(mm_req_wr && (rd0_addr == mm_Ab));
    rd1_cand   = rd1_req && !(mm_req_wr && (rd1_addr == mm_Ab));

    rd0_ack    = rst && rd0_cand && (!rd1_cand || !rd_last);
    rd1_ack    = rst && rd1_cand && (!rd0_cand || rd_last);

    wr_xfer    = alu_wr_ack || vld_wr_ack;
    rd_xfer    = rd0_ack || rd1_ack;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_last   <= 1'b0;
      rd_last   <= 1'b0;
      mm_Aa     <= '0;
      mm_Ab     <= '0;
      mm_Db     <= '0;
      mm_req_wr <= 1'b0;
      s1_valid  <= 1'b0;
      s1_id     <= 1'b0;
      s2_valid  <= 1'b0;
      s2_id     <= 1'b0;
    end else begin
      mm_req_wr <= wr_xfer;
      if (wr_xfer) begin
        mm_Ab   <= alu_wr_ack ? alu_wr_addr : vld_wr_addr;
        mm_Db   <= alu_wr_ack ? alu_wr_data : vld_wr_data;
        wr_last <= alu_wr_ack;
      end

      if (rd_xfer) begin
        mm_Aa   <= rd0_ack ? rd0_addr : rd1_addr;
        rd_last <= rd0_ack;
      end

      // Tag pipeline follows the read through mm's registered output.
      s1_valid <= rd_xfer;
      s1_id    <= rd1_ack;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
    end
  end

  assign rd0_vld = s2_valid && !s2_id;
  assign rd1_vld = s2_valid && s2_id;
  assign rd_data = mm_Da;

endmodule

// File: tb/tb_mm_arb.sv
// Bench for mm_arb: directed scenarios then random traffic, checked against a
// transaction-level model of arbitration and memory ordering.
module tb_mm_arb;
  localparam int AW = 31;
  localparam int DW = 63;
  localparam logic [DW:0] INIT = 64'hF0FF_F0FF_F0FF_F0FF;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          alu_wr_req = 1'b0, vld_wr_req = 1'b0;
  logic [AW:0]   alu_wr_addr = '0, vld_wr_addr = '0;
  logic [DW:0]   alu_wr_data = '0, vld_wr_data = '0;
  logic          alu_wr_ack, vld_wr_ack;
  logic          rd0_req = 1'b0, rd1_req = 1'b0;
  logic [AW:0]   rd0_addr = '0, rd1_addr = '0;
  logic          rd0_ack, rd1_ack, rd0_vld, rd1_vld;
  logic [DW:0]   rd_data;
  logic [AW:0]   mm_Aa, mm_Ab;
  logic [DW:0]   mm_Db;
  logic          mm_req_wr;
  logic [DW:0]   mm_Da = '0;

  mm_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .alu_wr_req(alu_wr_req), .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data), .alu_wr_ack(alu_wr_ack),
    .vld_wr_req(vld_wr_req), .vld_wr_addr(vld_wr_addr), .vld_wr_data(vld_wr_data), .vld_wr_ack(vld_wr_ack),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_ack(rd0_ack), .rd0_vld(rd0_vld),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_ack(rd1_ack), .rd1_vld(rd1_vld),
    .rd_data(rd_data),
    .mm_Aa(mm_Aa), .mm_Ab(mm_Ab), .mm_Db(mm_Db), .mm_req_wr(mm_req_wr), .mm_Da(mm_Da)
  );

  // The mm memory itself: registered read, read ordered before write on an edge.
  logic [DW:0] mem [logic [AW:0]];
  always @(posedge clk) begin
    mm_Da <= mem.exists(mm_Aa) ? mem[mm_Aa] : INIT;
    if (mm_req_wr) mem[mm_Ab] = mm_Db;
  end

  // reference model: last winners, port registers, memory contents, expected reads
  typedef struct {
    int          due;
    bit          id;
    logic [DW:0] data;
  } rd_exp_t;
  rd_exp_t     exp_q[$];
  logic [DW:0] shadow [logic [AW:0]];
  int          wr_prev, rd_prev;   // 0 = ALU/rd0 won last, 1 = VLD/rd1 won last
  bit          exp_req_wr;
  logic [AW:0] exp_Aa, exp_Ab;
  logic [DW:0] exp_Db;
  bit          pend_valid;
  logic [AW:0] pend_addr;
  logic [DW:0] pend_data;
  bit          exp_alu, exp_vld, exp_r0, exp_r1;
  bit          obs_alu, obs_vld, obs_r0, obs_r1;
  logic [DW:0] last_rd_data;
  int          last_vld_cyc, vld_cnt, wr_strobe_cnt;

  int n_pass = 0, n_total = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    wr_prev    = 1;
    rd_prev    = 1;
    exp_req_wr = 0;
    exp_Aa     = '0;
    exp_Ab     = '0;
    exp_Db     = '0;
    pend_valid = 0;
    exp_q.delete();
  endtask

  function automatic void model_acks();
    bit e0, e1;
    if (alu_wr_req && vld_wr_req) begin
      exp_alu = (wr_prev == 1);
      exp_vld = !exp_alu;
    end else begin
      exp_alu = alu_wr_req;
      exp_vld = vld_wr_req;
    end
    e0 = rd0_req && !(exp_req_wr && rd0_addr == exp_Ab);
    e1 = rd1_req && !(exp_req_wr && rd1_addr == exp_Ab);
    if (e0 && e1) begin
      exp_r0 = (rd_prev == 1);
      exp_r1 = !exp_r0;
    end else begin
      exp_r0 = e0;
      exp_r1 = e1;
    end
  endfunction

  // One clock: check mid-cycle, advance the model to the coming edge.
  task automatic cycle();
    rd_exp_t     e;
    logic [AW:0] ra;
    bit          ev0, ev1;
    logic [DW:0] ed;
    @(negedge clk);
    model_acks();
    obs_alu = alu_wr_ack; obs_vld = vld_wr_ack; obs_r0 = rd0_ack; obs_r1 = rd1_ack;
    chk("alu_wr_ack", alu_wr_ack, exp_alu);
    chk("vld_wr_ack", vld_wr_ack, exp_vld);
    chk("rd0_ack", rd0_ack, exp_r0);
    chk("rd1_ack", rd1_ack, exp_r1);
    chk("mm_req_wr", mm_req_wr, exp_req_wr);
    chk("mm_Ab", mm_Ab, exp_Ab);
    chk("mm_Db", mm_Db, exp_Db);
    chk("mm_Aa", mm_Aa, exp_Aa);
    ev0 = 0; ev1 = 0; ed = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e   = exp_q.pop_front();
      ev0 = !e.id;
      ev1 = e.id;
      ed  = e.data;
    end
    chk("rd0_vld", rd0_vld, ev0);
    chk("rd1_vld", rd1_vld, ev1);
    if (ev0 || ev1) chk("rd_data", rd_data, ed);
    if (rd0_vld || rd1_vld) begin
      last_rd_data = rd_data;
      last_vld_cyc = cyc;
      vld_cnt++;
    end
    if (mm_req_wr) wr_strobe_cnt++;

    // A read sees every write transferred on an earlier edge, not this one.
    if (pend_valid) shadow[pend_addr] = pend_data;
    pend_valid = 0;
    if (exp_r0 || exp_r1) begin
      ra     = exp_r0 ? rd0_addr : rd1_addr;
      e.due  = cyc + 2;
      e.id   = exp_r1;
      e.data = shadow.exists(ra) ? shadow[ra] : INIT;
      exp_q.push_back(e);
      exp_Aa  = ra;
      rd_prev = exp_r1 ? 1 : 0;
    end
    exp_req_wr = exp_alu || exp_vld;
    if (exp_req_wr) begin
      exp_Ab     = exp_alu ? alu_wr_addr : vld_wr_addr;
      exp_Db     = exp_alu ? alu_wr_data : vld_wr_data;
      pend_valid = 1;
      pend_addr  = exp_Ab;
      pend_data  = exp_Db;
      wr_prev    = exp_vld ? 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    alu_wr_req = 0; vld_wr_req = 0; rd0_req = 0; rd1_req = 0;
    repeat (n) cycle();
  endtask

  initial begin
    bit [3:0] alu_seq;
    bit [5:0] rd0_seq;
    int       base, xfer_cyc;

    // reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mm_Aa", mm_Aa, '0);
    chk("rst_mm_Ab", mm_Ab, '0);
    chk("rst_mm_Db", mm_Db, '0);
    chk("rst_mm_req_wr", mm_req_wr, 0);
    chk("rst_rd0_vld", rd0_vld, 0);
    chk("rst_rd1_vld", rd1_vld, 0);
    rst = 1;
    idle(1);

    // single read of an untouched address
    rd0_req = 1; rd0_addr = 5;
    cycle();
    xfer_cyc = cyc - 1;
    chk("single_rd_ack", obs_r0, 1);
    idle(3);
    chk("single_rd_latency", last_vld_cyc - xfer_cyc, 2);
    chk("single_rd_data", last_rd_data, INIT);

    // write contention
    base = wr_strobe_cnt;
    alu_wr_req = 1; alu_wr_addr = 10; alu_wr_data = 64'h0A;
    vld_wr_req = 1; vld_wr_addr = 20; vld_wr_data = 64'h14;
    for (int i = 0; i < 4; i++) begin
      cycle();
      alu_seq[3-i] = obs_alu;
    end
    idle(1);
    chk("wr_alternate", alu_seq, 4'b1010);
    chk("wr_strobe_cycles", wr_strobe_cnt - base, 4);
    idle(1);

    // read contention; rd0 won the previous read, so rd1 takes the first tie
    base = vld_cnt;
    rd0_req = 1; rd0_addr = 1;
    rd1_req = 1; rd1_addr = 2;
    for (int i = 0; i < 6; i++) begin
      cycle();
      rd0_seq[5-i] = obs_r0;
    end
    idle(3);
    chk("rd_alternate", rd0_seq, 6'b010101);
    chk("rd_no_bubbles", vld_cnt - base, 6);

    // read-after-write hazard
    alu_wr_req = 1; alu_wr_addr = 7; alu_wr_data = 64'h1234;
    cycle();
    alu_wr_req = 0;
    rd0_req = 1; rd0_addr = 7;
    rd1_req = 1; rd1_addr = 8;
    cycle();
    chk("raw_rd0_stalled", obs_r0, 0);
    chk("raw_rd1_granted", obs_r1, 1);
    rd1_req = 0;
    cycle();
    chk("raw_rd0_after_stall", obs_r0, 1);
    idle(3);
    chk("raw_data", last_rd_data, 64'h1234);

    // same-edge read and write of one address
    alu_wr_req = 1; alu_wr_addr = 3; alu_wr_data = 64'hAAAA;
    cycle();
    idle(1);
    alu_wr_req = 1; alu_wr_addr = 3; alu_wr_data = 64'hBBBB;
    rd0_req = 1; rd0_addr = 3;
    cycle();
    chk("same_edge_both_granted", {obs_alu, obs_r0}, 2'b11);
    idle(3);
    chk("same_edge_old_data", last_rd_data, 64'hAAAA);
    rd0_req = 1; rd0_addr = 3;
    cycle();
    idle(3);
    chk("same_edge_new_data", last_rd_data, 64'hBBBB);

    // random traffic on a small address window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      if (!alu_wr_req || exp_alu) begin
        alu_wr_req  = ($urandom_range(0, 9) < 6);
        alu_wr_addr = $urandom_range(0, 7);
        alu_wr_data = {$urandom, $urandom};
      end
      if (!vld_wr_req || exp_vld) begin
        vld_wr_req  = ($urandom_range(0, 9) < 6);
        vld_wr_addr = $urandom_range(0, 7);
        vld_wr_data = {$urandom, $urandom};
      end
      if (!rd0_req || exp_r0) begin
        rd0_req  = ($urandom_range(0, 9) < 6);
        rd0_addr = $urandom_range(0, 7);
      end
      if (!rd1_req || exp_r1) begin
        rd1_req  = ($urandom_range(0, 9) < 6);
        rd1_addr = $urandom_range(0, 7);
      end
      cycle();
    end
    idle(3);

    // reset with two reads and one write in flight
    rd0_req = 1; rd0_addr = 1;
    cycle();
    rd0_req = 0;
    rd1_req = 1; rd1_addr = 2;
    alu_wr_req = 1; alu_wr_addr = 100; alu_wr_data = 64'hDEAD;
    cycle();
    alu_wr_addr = 200; alu_wr_data = 64'hBEEF;
    vld_wr_req = 1; vld_wr_addr = 201; vld_wr_data = 64'h5;
    rd0_req = 1;
    rst = 0;
    #1;
    chk("mid_rst_alu_ack", alu_wr_ack, 0);
    chk("mid_rst_vld_ack", vld_wr_ack, 0);
    chk("mid_rst_rd0_ack", rd0_ack, 0);
    chk("mid_rst_rd1_ack", rd1_ack, 0);
    chk("mid_rst_mm_Aa", mm_Aa, '0);
    chk("mid_rst_mm_Ab", mm_Ab, '0);
    chk("mid_rst_mm_Db", mm_Db, '0);
    chk("mid_rst_mm_req_wr", mm_req_wr, 0);
    chk("mid_rst_rd0_vld", rd0_vld, 0);
    chk("mid_rst_rd1_vld", rd1_vld, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1;
    cycle();
    chk("post_rst_alu_first", obs_alu, 1);
    chk("post_rst_rd0_first", obs_r0, 1);
    idle(4);
    rd0_req = 1; rd0_addr = 100;
    cycle();
    idle(3);
    chk("rst_write_dropped", last_rd_data, INIT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
